// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the latency-modelled data-memory responder.
// Size codes, FSM states and the byte-lane mask/extension functions.
package dmem_responder_pkg;

  localparam int WORD_W = 64;
  localparam int LANES  = WORD_W / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    DR_IDLE = 2'b00,
    DR_BUSY = 2'b01,
    DR_RESP = 2'b10
  } dr_state_e;

  typedef struct packed {
    logic  write;
    size_e size;
    logic  sgn;
  } op_t;

  // Low address bits that must be zero for an aligned access.
  function automatic logic [2:0] size_mask(size_e s);
    logic [2:0] m;
    unique case (s)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [LANES-1:0] size_be(size_e s);
    logic [LANES-1:0] be;
    unique case (s)
      SZ_B:    be = 8'h01;
      SZ_H:    be = 8'h03;
      SZ_W:    be = 8'h0F;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  function automatic logic [WORD_W-1:0] extend(
    logic [WORD_W-1:0] v,
    size_e             s,
    logic              sg
  );
    logic [WORD_W-1:0] r;
    unique case (s)
      SZ_B: r = sg ? {{56{v[7]}}, v[7:0]}
                   : {56'b0, v[7:0]};
      SZ_H: r = sg ? {{48{v[15]}}, v[15:0]}
                   : {48'b0, v[15:0]};
      SZ_W: r = sg ? {{32{v[31]}}, v[31:0]}
                   : {32'b0, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_bytearray.sv
// Single-port synchronous RAM with per-byte write enables.
// The read word is registered on every enabled edge.
module dmem_bytearray
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [LANES-1:0]  be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < LANES; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with a fixed modelled latency.
// One access in flight; commit happens on the edge that enters RESP.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WORD        = WORD_W,
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW =
    (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [WORD-1:0] LIMIT =
    WORD'(DEPTH_WORDS * 8);

  dr_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_t             op_q, op_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;

  logic            in_idle, accept, commit;
  op_t             op_req, cur_op;
  logic [WORD-1:0] cur_addr, cur_wdata;
  logic            cur_err;

  logic [LANES-1:0]  ram_be;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;
  logic [WORD_W-1:0] ld_shift, ld_ext;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DR_IDLE: begin
        if (req_valid) begin
          state_d = (LATENCY == 1) ? DR_RESP
                                   : DR_BUSY;
        end
      end
      DR_BUSY: begin
        if (cnt_q == '0) state_d = DR_RESP;
      end
      DR_RESP: begin
        if (resp_ready) state_d = DR_IDLE;
      end
      default: state_d = DR_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready  = (state_q == DR_IDLE);
    resp_valid = (state_q == DR_RESP);
  end

  assign in_idle = (state_q == DR_IDLE);
  assign accept  = in_idle & req_valid;
  assign commit  = (state_d == DR_RESP) &
                   (state_q != DR_RESP);

  always_comb begin
    op_req.write = req_write;
    op_req.size  = size_e'(req_size);
    op_req.sgn   = req_signed;
  end

  // With LATENCY=1 the commit edge is the accept edge,
  // so the access is taken straight from the request.
  assign cur_op    = in_idle ? op_req    : op_q;
  assign cur_addr  = in_idle ? req_addr  : addr_q;
  assign cur_wdata = in_idle ? req_wdata : wdata_q;

  assign cur_err =
    (|(cur_addr[2:0] & size_mask(cur_op.size))) |
    (cur_addr >= LIMIT);

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (accept) begin
      op_d    = op_req;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      cnt_d   = CNT_INIT;
    end else if ((state_q == DR_BUSY) &&
                 (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (commit) err_d = cur_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ram_be    = size_be(cur_op.size) << cur_addr[2:0];
    ram_wdata = cur_wdata << {cur_addr[2:0], 3'b000};
  end

  dmem_bytearray #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .en_i    (commit & ~reset),
    .we_i    (cur_op.write & ~cur_err),
    .be_i    (ram_be),
    .addr_i  (cur_addr[3 +: AW]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // The RAM read register holds the sampled word for all of RESP.
  always_comb begin
    ld_shift = ram_rdata >> {addr_q[2:0], 3'b000};
    ld_ext   = extend(ld_shift, op_q.size, op_q.sgn);
  end

  assign resp_rdata =
    (resp_valid & ~err_q & ~op_q.write) ? ld_ext : '0;
  assign resp_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan plus
// random loads/stores against a byte-array reference model.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 128;
  localparam int BYTES = DEPTH * 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem_m [BYTES];

  dmem_responder #(
    .WORD        (64),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat little-endian byte array.
  task automatic model(input logic w,
                       input logic [1:0] sz,
                       input logic sg,
                       input logic [63:0] a,
                       input logic [63:0] wd,
                       output logic [63:0] rd,
                       output logic er);
    int n;
    n  = 1 << sz;
    er = ((a % 64'(n)) != 0) || (a >= 64'(BYTES));
    rd = '0;
    if (!er) begin
      for (int i = 0; i < n; i++) begin
        if (w) mem_m[int'(a) + i] = wd[8*i +: 8];
        else rd = rd | (64'(mem_m[int'(a) + i]) << (8*i));
      end
      if (!w && sg && sz != 2'd3 && rd[8*n-1])
        rd = rd | (~64'd0 << (8*n));
    end
  endtask

  task automatic send(input logic w,
                      input logic [1:0] sz,
                      input logic sg,
                      input logic [63:0] a,
                      input logic [63:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Edges counted from the accepting edge (that edge is 1).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("resp_arrives", 64'(resp_valid), 64'd1);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic w,
                        input logic [1:0] sz,
                        input logic sg,
                        input logic [63:0] a,
                        input logic [63:0] wd,
                        output logic [63:0] rd_o);
    logic [63:0] erd, rd;
    logic        eer, er;
    int          lat;
    model(w, sz, sg, a, wd, erd, eer);
    send(w, sz, sg, a, wd);
    wait_valid(lat);
    rd = resp_rdata;
    er = resp_err;
    handshake();
    check({tag, ".rdata"}, rd, erd);
    check({tag, ".err"}, 64'(er), 64'(eer));
    check({tag, ".lat"}, 64'(lat), 64'(LAT));
    check({tag, ".vclr"}, 64'(resp_valid), 64'd0);
    rd_o = rd;
  endtask

  initial begin
    logic [63:0] rd, rd0, erd;
    logic        er0, eer;
    logic        w, sg;
    logic [1:0]  sz;
    logic [63:0] a;
    int          lat;

    #12;
    check("rst.req_ready", 64'(req_ready), 64'd1);
    check("rst.resp_valid", 64'(resp_valid), 64'd0);
    check("rst.rdata", resp_rdata, 64'd0);
    check("rst.err", 64'(resp_err), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++)
      run_op("fill", 1'b1, 2'd3, 1'b0, 64'(i * 8),
             {$urandom, $urandom}, rd);

    run_op("st_d", 1'b1, 2'd3, 1'b0, 64'h10,
           64'h0123456789ABCDEF, rd);
    run_op("ld_d", 1'b0, 2'd3, 1'b0, 64'h10, '0, rd);
    check("ld_d.const", rd, 64'h0123456789ABCDEF);

    run_op("st_b", 1'b1, 2'd0, 1'b0, 64'h13, 64'hFF, rd);
    run_op("ld_bs", 1'b0, 2'd0, 1'b1, 64'h13, '0, rd);
    check("ld_bs.const", rd, 64'hFFFFFFFFFFFFFFFF);
    run_op("ld_bu", 1'b0, 2'd0, 1'b0, 64'h13, '0, rd);
    check("ld_bu.const", rd, 64'h00000000000000FF);
    run_op("ld_d2", 1'b0, 2'd3, 1'b0, 64'h10, '0, rd);
    check("ld_d2.const", rd, 64'h01234567FFABCDEF);

    run_op("mis_w", 1'b0, 2'd2, 1'b0, 64'h12, '0, rd);
    run_op("mis_st", 1'b1, 2'd3, 1'b0, 64'h14,
           64'hDEADBEEFDEADBEEF, rd);
    run_op("ld_d3", 1'b0, 2'd3, 1'b0, 64'h10, '0, rd);
    check("ld_d3.const", rd, 64'h01234567FFABCDEF);

    run_op("oor", 1'b0, 2'd3, 1'b0, 64'(BYTES), '0, rd);

    // Backpressure with a competing request held on the bus.
    model(1'b0, 2'd3, 1'b0, 64'h10, '0, erd, eer);
    send(1'b0, 2'd3, 1'b0, 64'h10, '0);
    wait_valid(lat);
    rd0 = resp_rdata;
    er0 = resp_err;
    check("bp.rdata", rd0, erd);
    check("bp.err", 64'(er0), 64'(eer));
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd0;
    req_signed = 1'b0;
    req_addr  = 64'h20;
    req_wdata = 64'h5A;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp.valid", 64'(resp_valid), 64'd1);
      check("bp.hold_rd", resp_rdata, rd0);
      check("bp.hold_err", 64'(resp_err), 64'(er0));
      check("bp.req_ready", 64'(req_ready), 64'd0);
    end
    handshake();
    check("bp.hs_valid", 64'(resp_valid), 64'd0);
    check("bp.hs_ready", 64'(req_ready), 64'd1);
    model(1'b1, 2'd0, 1'b0, 64'h20, 64'h5A, erd, eer);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("bp.accepted", 64'(req_ready), 64'd0);
    wait_valid(lat);
    check("bp2.lat", 64'(lat), 64'(LAT));
    check("bp2.err", 64'(resp_err), 64'(eer));
    handshake();
    run_op("bp_ld", 1'b0, 2'd0, 1'b0, 64'h20, '0, rd);
    check("bp_ld.const", rd, 64'h5A);

    // Reset during BUSY drops the store.
    send(1'b1, 2'd3, 1'b0, 64'h10, 64'hAAAAAAAAAAAAAAAA);
    reset = 1'b1;
    #1;
    check("mid.resp_valid", 64'(resp_valid), 64'd0);
    check("mid.req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    run_op("mid_ld", 1'b0, 2'd3, 1'b0, 64'h10, '0, rd);
    check("mid_ld.const", rd, 64'h01234567FFABCDEF);

    for (int k = 0; k < 60; k++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = 64'(BYTES + $urandom_range(0, 63));
      else
        a = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0)
        a = a & ~64'((1 << sz) - 1);
      run_op("rand", w, sz, sg, a,
             {$urandom, $urandom}, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
